uart_tx_path: RTL and testbench
===============================

# uart_tx_path

Transmit-side UART path: an 8-deep write FIFO, an internal baud-tick generator and a framing state machine. Together they serialize buffered bytes onto `tx` as start, data (LSB first), optional parity and stop bits. The block is the transmit counterpart of the receive path and shares its 16-ticks-per-bit oversampling convention, so one `input_number` value drives both ends at the same baud rate.

## Interface
Parameters:
- `D_bit`, 8: data bits per frame.
- `stop_tick`, 32: stop-bit duration in s_ticks (16 = 1 stop bit, 32 = 2 stop bits).
- `depth`, 8: FIFO entries; must be a power of two.
- `bit`, 10: width of the baud divider.

Ports:
- `clk`  in  1  Single clock. All logic is rising-edge.
- `rst`  in  1  Synchronous, active-high reset.
- `write_en`  in  1  Push `write_data` into the FIFO.
- `write_data`  in  D_bit  Byte to transmit.
- `full`  out  1  FIFO holds `depth` entries.
- `input_number`  in  bit  Baud divider. The s_tick period is `input_number+1` clocks.
- `tx`  out  1  Serial line; idles high.
- `tx_busy`  out  1  High from start bit through end of stop bit.
- `tx_done`  out  1  One-cycle pulse in the last cycle of the stop bit.

## Operation
- Tick generator:
  - Counter counts 0..`input_number` and asserts an internal s_tick for one clock at terminal count, then wraps to 0.
  - The counter is forced to 0 in the cycle the FSM leaves IDLE.
  - `input_number`=0 gives an s_tick every clock.
- FIFO:
  - Circular buffer with a count register.
  - A write while `full` is dropped, with no state change.
  - A write and a pop in the same cycle while full are both accepted; the count is unchanged.
  - Pop happens only from the FSM in IDLE.
- FSM states:
  - IDLE: `tx`=1. If FIFO is non-empty, pop the head into the shift register, clear the sample counter, and go to START.
  - START: `tx`=0 for 16 s_ticks, then go to DATA.
  - DATA: `tx`=shreg[0]. Every 16 s_ticks, shift right and increment the bit index. After `D_bit` bits, go to PARITY if enabled, else STOP.
  - PARITY: `tx`=parity bit for 16 s_ticks, then go to STOP.
  - STOP: `tx`=1 for `stop_tick` s_ticks. `tx_done` pulses on the final tick. Then go to IDLE.
- Sample counter: increments on s_tick; the state advances on the s_tick where the count equals limit−1.
- Back-to-back frames: if the FIFO is non-empty at return to IDLE, the next START begins one clock after leaving STOP (exactly one idle-high clock between frames).
- `tx`, `tx_busy` and `tx_done` are registered outputs.

## Timing
- Reset values: `tx`=1, `tx_busy`=0, `tx_done`=0, `full`=0, FIFO empty, FSM in IDLE, tick counter 0.
- Reset asserted mid-frame: on the next edge `tx`=1, the FIFO is cleared and the FSM is in IDLE.
- Latency:
  - A write to an empty FIFO while in IDLE: `tx` falls 2 clocks after the write edge (1 clock FIFO write, 1 clock pop/START).
  - Bit period is exactly 16·(`input_number`+1) clocks, because the prescaler restarts at START.
- Frame length in clocks is (16·(1+`D_bit`)+`stop_tick`[+16])·(`input_number`+1).
- `full` updates in the clock after the push that fills the FIFO; it deasserts the clock after a pop.
- A change to `input_number` mid-frame takes effect at the next counter wrap. This is unsupported for correct framing.

## Configuration
- `TX_PARITY_EN` defined:
  - The PARITY state is compiled in.
  - The parity bit is even parity (XOR of the data bits), inserted after the last data bit.
  - Frame length grows by 16 s_ticks.
- `TX_PARITY_EN` undefined:
  - No PARITY state and no parity logic.
  - DATA goes directly to STOP.

## Test plan
- Reset: hold `rst` for 3 clocks mid-frame, with the FIFO holding 3 bytes. Required: `tx`=1, `tx_busy`=0, `full`=0 on the next clock, and no further transmission.
- Single byte (no parity, `input_number`=0, `stop_tick`=32): write 0x55. Required:
  - `tx` levels 0,1,0,1,0,1,0,1,0 with each level held 16 clocks, then 1 for 32 clocks.
  - `tx_done` pulses 176 clocks after the `tx` falling edge.
- Divider: `input_number`=3, write 0xA0. Required: every bit lasts 64 clocks; data bits sent LSB first are 0,0,0,0,0,1,0,1.
- FIFO full: write 9 bytes 0x01..0x09 on consecutive clocks while IDLE. Required:
  - The first byte is popped immediately, so all 9 are accepted (`full` asserts after byte 9).
  - A 10th write of 0xFF is dropped.
  - Transmission order is 0x01..0x09, back-to-back with 1 idle clock between frames.
- Parity (`TX_PARITY_EN`): send 0x07. Required: parity bit 1, `tx_done` at 192 clocks after start (`input_number`=0). Send 0x03: parity bit 0.
- Simultaneous push/pop at full: FIFO full, FSM in IDLE, write 0x3C in the pop cycle. Required: `full` stays high and 0x3C is transmitted last.

Source files
------------

// File: rtl/uart_tx_path.sv
// Transmit-side UART: write FIFO, 16x-oversampled baud tick generator and a framing FSM.
// Define TX_PARITY_EN to add an even-parity bit after the last data bit.
module uart_tx_path #(
  parameter int D_bit     = 8,
  parameter int stop_tick = 32,
  parameter int depth     = 8,
  parameter int bit_w     = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             write_en,
  input  logic [D_bit-1:0] write_data,
  output logic             full,
  input  logic [bit_w-1:0] input_number,
  output logic             tx,
  output logic             tx_busy,
  output logic             tx_done
);

  localparam int AW  = (depth > 1) ? $clog2(depth) : 1;
  localparam int CW  = $clog2(depth + 1);
  localparam int BW  = (D_bit > 1) ? $clog2(D_bit) : 1;
  localparam int LIM = (stop_tick > 16) ? stop_tick : 16;
  localparam int SW  = $clog2(LIM);

  localparam logic [SW-1:0] BIT_LAST  = SW'(15);
  localparam logic [SW-1:0] STOP_LAST = SW'(stop_tick - 1);
  localparam logic [BW-1:0] IDX_LAST  = BW'(D_bit - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  // ---------------------------------------------------------------- FIFO
  logic [D_bit-1:0] mem_q [depth];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop, empty;

  assign full  = (count_q == CW'(depth));
  assign empty = (count_q == '0);
  // A pop in the same cycle frees a slot, so a write at full is still taken.
  assign push  = write_en && (!full || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it is tested inside the clocked block, not in the sensitivity list.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; count_q alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= write_data;
  end

  // -------------------------------------------------------- tick generator
  logic [bit_w-1:0] tick_q, tick_d;
  logic             s_tick, tick_clr;

  assign s_tick = (tick_q == input_number);

  always_comb begin
    tick_d = tick_q + bit_w'(1);
    if (tick_clr || s_tick) tick_d = '0;
  end

  // ------------------------------------------------------------------ FSM
  state_t           state_q, state_d;
  logic [SW-1:0]    s_cnt_q, s_cnt_d;
  logic [BW-1:0]    bit_idx_q, bit_idx_d;
  logic [D_bit-1:0] shreg_q, shreg_d;
  logic             tx_q, tx_d, busy_q, busy_d, done_q, done_d;
`ifdef TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    s_cnt_d   = s_tick ? s_cnt_q + SW'(1) : s_cnt_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    pop       = 1'b0;
    tick_clr  = 1'b0;
    tx_d      = 1'b1;
    busy_d    = 1'b1;
    done_d    = 1'b0;
`ifdef TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        busy_d  = 1'b0;
        s_cnt_d = '0;
        if (!empty) begin
          pop       = 1'b1;
          tick_clr  = 1'b1;
          shreg_d   = mem_q[rd_ptr_q];
          bit_idx_d = '0;
          state_d   = S_START;
`ifdef TX_PARITY_EN
          parity_d  = ^mem_q[rd_ptr_q];
`endif
        end
      end
      S_START: begin
        tx_d = 1'b0;
        if (s_tick && s_cnt_q == BIT_LAST) begin
          s_cnt_d = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        tx_d = shreg_q[0];
        if (s_tick && s_cnt_q == BIT_LAST) begin
          s_cnt_d = '0;
          shreg_d = shreg_q >> 1;
          if (bit_idx_q == IDX_LAST) begin
            bit_idx_d = '0;
`ifdef TX_PARITY_EN
            state_d   = S_PARITY;
`else
            state_d   = S_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + BW'(1);
          end
        end
      end
`ifdef TX_PARITY_EN
      S_PARITY: begin
        tx_d = parity_q;
        if (s_tick && s_cnt_q == BIT_LAST) begin
          s_cnt_d = '0;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (s_tick && s_cnt_q == STOP_LAST) begin
          s_cnt_d = '0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the current state, so the line lags the FSM by one clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      tick_q    <= '0;
      s_cnt_q   <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      s_cnt_q   <= s_cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_path.sv
// Bench for uart_tx_path: a line monitor decodes frames from tx by bit period and
// compares them with a queue of the bytes the FIFO should accept.
module tb_uart_tx_path;

  localparam int D_BIT     = 8;
  localparam int STOP_TICK = 32;
  localparam int DEPTH     = 8;
  localparam int BIT_W     = 10;
`ifdef TX_PARITY_EN
  localparam int PAR_BITS  = 1;
`else
  localparam int PAR_BITS  = 0;
`endif
  localparam int FRAME_PERIODS = 1 + D_BIT + PAR_BITS + STOP_TICK / 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             write_en = 1'b0;
  logic [D_BIT-1:0] write_data = '0;
  logic             full, tx, tx_busy, tx_done;
  logic [BIT_W-1:0] input_number;
  int               cur_n = 0;

  assign input_number = BIT_W'(cur_n);

  always #5 clk = ~clk;

  uart_tx_path #(
    .D_bit(D_BIT), .stop_tick(STOP_TICK), .depth(DEPTH), .bit_w(BIT_W)
  ) dut (
    .clk(clk), .rst(rst), .write_en(write_en), .write_data(write_data),
    .full(full), .input_number(input_number),
    .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: bytes the FIFO must accept, in send order.
  logic [7:0] exp_q[$];

  // Monitor results.
  logic [7:0] got_q[$];
  logic       par_q[$];
  int         gap_q[$];
  int         n_abort = 0;
  int         stray_done = 0;

  int         mon_idle, mon_per, mon_flen, mon_shape, mon_busy, mon_dcnt, mon_didx;
  logic       mon_bv [0:15];
  logic [7:0] mon_d;
  bit         mon_abort;

  initial begin : monitor
    mon_idle = 0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0 || tx !== 1'b0) begin
        if (tx_done === 1'b1) stray_done++;
        mon_idle++;
      end else begin
        mon_per   = 16 * (cur_n + 1);
        mon_flen  = FRAME_PERIODS * mon_per;
        mon_shape = 0;
        mon_busy  = 0;
        mon_dcnt  = 0;
        mon_didx  = -1;
        mon_abort = 1'b0;
        for (int i = 0; i < mon_flen; i++) begin
          if (i > 0) @(negedge clk);
          if (rst !== 1'b0) begin
            mon_abort = 1'b1;
            break;
          end
          if (i % mon_per == 0) mon_bv[i / mon_per] = tx;
          else if (tx !== mon_bv[i / mon_per]) mon_shape++;
          if (tx_busy !== 1'b1) mon_busy++;
          if (tx_done === 1'b1) begin
            mon_dcnt++;
            mon_didx = i;
          end
        end
        if (mon_abort) begin
          n_abort++;
        end else begin
          for (int b = 0; b < D_BIT; b++) mon_d[b] = mon_bv[1 + b];
          for (int j = 1 + D_BIT + PAR_BITS; j < FRAME_PERIODS; j++)
            if (mon_bv[j] !== 1'b1) mon_shape++;
          check("frame_shape", mon_shape, 0);
          check("frame_busy", mon_busy, 0);
          check("done_count", mon_dcnt, 1);
          check("done_pos", mon_didx, mon_flen - 1);
          got_q.push_back(mon_d);
          gap_q.push_back(mon_idle);
          par_q.push_back(mon_bv[1 + D_BIT]);
        end
        mon_idle = 0;
      end
    end
  end

  task automatic push(input logic [7:0] d);
    write_en   = 1'b1;
    write_data = d;
    @(negedge clk);
    write_en   = 1'b0;
  endtask

  task automatic wait_frames(input int k, input int max_cycles);
    int w;
    w = 0;
    while (got_q.size() < k && w < max_cycles) begin
      @(negedge clk);
      w++;
    end
    check("wait_frames", got_q.size() >= k, 1);
  endtask

  // Compares decoded frames with the model; frames after the first must follow with one idle clock.
  task automatic drain(input string tag, input int max_cycles);
    int w, k, g;
    w = 0;
    k = 0;
    while (got_q.size() < exp_q.size() && w < max_cycles) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_frames"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      check({tag, "_data"}, got_q.pop_front(), exp_q.pop_front());
      g = gap_q.pop_front();
      if (k > 0) check({tag, "_gap"}, g, 1);
      k++;
    end
    exp_q.delete();
    got_q.delete();
    gap_q.delete();
    par_q.delete();
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int low_cnt, k;
    logic [7:0] b;

    // Reset state.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_done", tx_done, 0);
    check("rst_full", full, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single byte: tx falls two clocks after the write edge.
    cur_n = 0;
    push(8'h55);
    exp_q.push_back(8'h55);
    check("lat_e0", tx, 1);
    @(negedge clk);
    check("lat_e1", tx, 1);
    @(negedge clk);
    check("lat_e2", tx, 0);
    drain("single", 1000);

    // Divider: 64-clock bits.
    cur_n = 3;
    push(8'hA0);
    exp_q.push_back(8'hA0);
    drain("div", 2000);

    // Fill the FIFO, drop a write at full, then push during the pop at frame end.
    cur_n = 0;
    for (int i = 1; i <= 9; i++) begin
      write_en   = 1'b1;
      write_data = 8'(i);
      exp_q.push_back(8'(i));
      @(negedge clk);
      if (i == 8) check("full_at8", full, 0);
    end
    check("full_at9", full, 1);
    write_data = 8'hFF;
    @(negedge clk);
    write_en = 1'b0;
    check("full_drop", full, 1);
    k = 0;
    while (tx_done !== 1'b1 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check("pop_wait", tx_done, 1);
    check("full_before_pop", full, 1);
    push(8'h3C);
    exp_q.push_back(8'h3C);
    check("full_pushpop", full, 1);
    drain("fifo", 4000);

    // Randomized bursts at random dividers.
    for (int r = 0; r < 4; r++) begin
      cur_n = $urandom_range(0, 2);
      k = $urandom_range(1, 5);
      for (int j = 0; j < k; j++) begin
        b = 8'($urandom);
        push(b);
        exp_q.push_back(b);
      end
      drain("rand", 6000);
    end

`ifdef TX_PARITY_EN
    cur_n = 0;
    push(8'h07);
    exp_q.push_back(8'h07);
    wait_frames(1, 1000);
    check("par_07", (par_q.size() > 0) ? 32'(par_q[0]) : 32'hDEAD, 1);
    drain("par07", 1000);
    push(8'h03);
    exp_q.push_back(8'h03);
    wait_frames(1, 1000);
    check("par_03", (par_q.size() > 0) ? 32'(par_q[0]) : 32'hDEAD, 0);
    drain("par03", 1000);
`endif

    // Reset mid-frame with three bytes still queued.
    cur_n = 0;
    for (int j = 0; j < 4; j++) push(8'h11 * (j + 1));
    repeat (40) @(negedge clk);
    check("pre_rst_busy", tx_busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_tx", tx, 1);
    check("midrst_busy", tx_busy, 0);
    check("midrst_full", full, 0);
    check("midrst_done", tx_done, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    low_cnt = 0;
    repeat (800) begin
      @(negedge clk);
      if (tx !== 1'b1) low_cnt++;
    end
    check("rst_quiet", low_cnt, 0);
    check("rst_no_frames", got_q.size(), 0);
    check("rst_abort", n_abort, 1);
    check("stray_done", stray_done, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
